// File: rtl/bridge_timer_if.sv
// Bridge-side bus bundle for the interval timer: word address, select,
// write strobe, write data, read data and the interrupt line.
interface bridge_timer_if;
  logic [1:0]  Addr;
  logic        sel;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, sel, WE, Din, input Dout, IRQ);
  modport slave  (input Addr, sel, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/bridge_timer.sv
// Memory-mapped interval timer (one-shot / auto-reload) driving one CPU interrupt.
// Optional build macro TIMER_COUNT_WR_EN makes COUNT (offset 2) writable.
module bridge_timer (
  input  logic          clk,
  input  logic          reset,
  bridge_timer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  state_e      state_q;
  logic        en_q;
  logic [1:0]  mode_q;
  logic        im_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_q;

  logic ctrl_wr;
  logic preset_wr;

  assign ctrl_wr   = bus.sel && bus.WE && (bus.Addr == 2'd0);
  assign preset_wr = bus.sel && bus.WE && (bus.Addr == 2'd1);

`ifdef TIMER_COUNT_WR_EN
  logic count_wr;
  assign count_wr = bus.sel && bus.WE && (bus.Addr == 2'd2);
`endif

  // Timer FSM, register file and interrupt flag; later assignments take priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      irq_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en_q) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          count_q <= preset_q;
          state_q <= S_CNT;
        end
        S_CNT: begin
          if (!en_q) begin
            state_q <= S_IDLE;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            count_q <= 32'd0;
            state_q <= S_INT;
          end
        end
        S_INT: begin
          state_q <= S_IDLE;
          if (mode_q != 2'b01) begin
            en_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Auto-reload turns the flag into a single-cycle pulse.
      if (ctrl_wr) begin
        irq_q <= 1'b0;
      end else if (state_q == S_INT) begin
        irq_q <= 1'b1;
      end else if (mode_q == 2'b01) begin
        irq_q <= 1'b0;
      end

      if (preset_wr) begin
        preset_q <= bus.Din;
      end

      // A CTRL write overrides the one-shot EN clear landing on the same edge.
      if (ctrl_wr) begin
        en_q   <= bus.Din[0];
        mode_q <= bus.Din[2:1];
        im_q   <= bus.Din[3];
      end

`ifdef TIMER_COUNT_WR_EN
      if (count_wr) begin
        count_q <= bus.Din;
      end
`endif
    end
  end

  // Zero-latency read mux.
  always_comb begin
    bus.Dout = 32'd0;
    case (bus.Addr)
      2'd0:    bus.Dout = {28'd0, im_q, mode_q, en_q};
      2'd1:    bus.Dout = preset_q;
      2'd2:    bus.Dout = count_q;
      default: bus.Dout = 32'd0;
    endcase
  end

  assign bus.IRQ = irq_q & im_q;

endmodule

// File: tb/tb_bridge_timer.sv
// Directed bench for bridge_timer: expectations are queued by the stimulus
// and compared by an independent negedge monitor.
module tb_bridge_timer;

  logic clk;
  logic reset;

  bridge_timer_if bus ();

  bridge_timer u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] dout;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected stimulus to complete");
    $fatal(1, "watchdog expired");
  end

  // Monitor: compare every expectation queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total = total + 1;
      if (bus.Dout !== e.dout || bus.IRQ !== e.irq) begin
        bad = bad + 1;
        $display("FAIL %s: got Dout=%h IRQ=%b, expected Dout=%h IRQ=%b",
                 e.name, bus.Dout, bus.IRQ, e.dout, e.irq);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [1:0] a, input logic [31:0] d, input logic irq);
    exp_t e;
    bus.Addr = a;
    e.name = nm;
    e.dout = d;
    e.irq  = irq;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.Din  = d;
    bus.sel  = 1'b1;
    bus.WE   = 1'b1;
    step();
    bus.sel  = 1'b0;
    bus.WE   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int c;
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    bus.Addr = 2'd0;
    bus.sel  = 1'b0;
    bus.WE   = 1'b0;
    bus.Din  = 32'd0;
    step();
    step();
    reset = 1'b0;

    // Reset values and register-map boundaries
    for (int a = 0; a < 4; a++) begin
      chk("reset_read", 2'(a), 32'd0, 1'b0);
      step();
    end
    wr(2'd0, 32'hFFFF_FFF6);
    chk("ctrl_upper_bits", 2'd0, 32'h0000_0006, 1'b0);
    step();
    wr(2'd3, 32'h0000_1234);
    chk("reserved_read", 2'd3, 32'd0, 1'b0);
    step();
    wr(2'd2, 32'h0000_0077);
`ifdef TIMER_COUNT_WR_EN
    chk("count_write", 2'd2, 32'h0000_0077, 1'b0);
`else
    chk("count_write_ignored", 2'd2, 32'd0, 1'b0);
`endif
    step();
    do_reset();

    // One-shot, PRESET=5: IRQ high after E8
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 0; k <= 8; k++) begin
      if (k < 2) c = 0;
      else if (k - 2 >= 5) c = 0;
      else c = 5 - (k - 2);
      chk("oneshot_count", 2'd2, 32'(c), (k >= 8) ? 1'b1 : 1'b0);
      step();
    end
    chk("oneshot_ctrl_en_cleared", 2'd0, 32'h8, 1'b1);
    step();
    chk("oneshot_irq_holds", 2'd2, 32'd0, 1'b1);
    step();
    wr(2'd1, 32'd3);
    chk("preset_write_keeps_count", 2'd2, 32'd0, 1'b1);
    step();
    wr(2'd0, 32'h8);
    chk("ctrl_write_clears_irq", 2'd0, 32'h8, 1'b0);
    step();

    // Auto-reload, PRESET=3: pulses after E6, E12, E18, E24
    wr(2'd0, 32'hB);
    for (int k = 0; k <= 25; k++) begin
      chk("reload_pulse", 2'd0, 32'hB, (k >= 6 && (k % 6) == 0) ? 1'b1 : 1'b0);
      step();
    end

    // Reset mid-count overrides a simultaneous CTRL write
    bus.Addr = 2'd0;
    bus.Din  = 32'hF;
    bus.sel  = 1'b1;
    bus.WE   = 1'b1;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    bus.sel  = 1'b0;
    bus.WE   = 1'b0;
    for (int a = 0; a < 4; a++) begin
      chk("midcount_reset_read", 2'(a), 32'd0, 1'b0);
      step();
    end

    // Stop at COUNT=60: the write edge still decrements, then COUNT freezes
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    repeat (41) step();
    chk("stop_before", 2'd2, 32'd61, 1'b0);
    step();
    wr(2'd0, 32'h8);
    chk("stop_write_edge", 2'd2, 32'd59, 1'b0);
    step();
    chk("stop_frozen", 2'd2, 32'd59, 1'b0);
    step();
    chk("stop_ctrl", 2'd0, 32'h8, 1'b0);
    step();
    chk("stop_still_frozen", 2'd2, 32'd59, 1'b0);
    step();
    wr(2'd0, 32'h9);
    chk("reenable_ctrl", 2'd0, 32'h9, 1'b0);
    step();
    chk("reenable_idle_to_load", 2'd2, 32'd59, 1'b0);
    step();
    chk("reenable_reload", 2'd2, 32'd100, 1'b0);
    step();
    chk("reenable_decrement", 2'd2, 32'd99, 1'b0);
    step();
    do_reset();

    // PRESET=0 with IM clear: EN drops at E4, IRQ stays low
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    for (int k = 0; k <= 5; k++) begin
      chk("preset0_ctrl", 2'd0, (k >= 4) ? 32'h0 : 32'h1, 1'b0);
      step();
    end
    wr(2'd0, 32'h8);
    chk("preset0_flag_cleared", 2'd0, 32'h8, 1'b0);
    step();
    chk("preset0_irq_low", 2'd0, 32'h8, 1'b0);
    step();
    do_reset();

    // CTRL write on the INT edge wins over the one-shot EN clear
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    step();
    step();
    chk("conflict_count1", 2'd2, 32'd1, 1'b0);
    step();
    wr(2'd0, 32'hB);
    chk("conflict_ctrl_wins", 2'd0, 32'hB, 1'b0);
    step();
    chk("conflict_flag_clear", 2'd0, 32'hB, 1'b0);
    step();
    do_reset();

    // COUNT write at COUNT=40
    wr(2'd1, 32'd50);
    wr(2'd0, 32'h9);
    repeat (11) step();
    chk("cntwr_before", 2'd2, 32'd41, 1'b0);
    step();
    wr(2'd2, 32'd2);
    for (int k = 0; k < 4; k++) begin
`ifdef TIMER_COUNT_WR_EN
      chk("cntwr_to_int", 2'd2, (k < 2) ? 32'(2 - k) : 32'd0, (k == 3) ? 1'b1 : 1'b0);
`else
      chk("cntwr_ignored", 2'd2, 32'(39 - k), 1'b0);
`endif
      step();
    end

    step();
    step();
    if (total < 12) begin
      bad = bad + 1;
      $display("FAIL check_count: only %0d checks executed, expected at least 12", total);
    end
    if (bad != 0) begin
      $display("FAIL summary: %0d of %0d checks failed", bad, total);
    end else begin
      $display("PASS summary: all %0d checks passed", total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
